// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO reader: state encoding, LFSR taps and
// rate full-scale value.
package fifo_rd_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [8:0]  RATE_FULL = 9'd256;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/fifo_reader_lfsr16.sv
// 16-bit Galois LFSR with enable; holds its value while en is low.
module lfsr16
  import fifo_rd_defs::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a fixed-length block from a standard FIFO read port at a
// pseudo-random rate and tags each captured word with its block index.
module fifo_reader
  import fifo_rd_defs::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          MAX_BLOCK_SIZE = 1024,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         CNT_W          = $clog2(MAX_BLOCK_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic [8:0]       rate,
  output logic             rden,
  input  logic [WIDTH-1:0] din,
  input  logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] dout_index,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [8:0]       r_rate;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_received;
  logic             r_rd;
  logic [WIDTH-1:0] r_dout;
  logic             r_done0;

  logic [15:0]      w_lfsr;
  logic             w_gate;
  logic             w_rden;
  logic             w_last;
  logic [CNT_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_issued_next;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (r_state == RUN),
    .q   (w_lfsr)
  );

  assign w_gate = (r_rate >= RATE_FULL) || ({1'b0, w_lfsr[15:8]} < r_rate);
  assign w_rden = (r_state == RUN) && w_gate && !empty && (r_issued < r_len);

  // The word being presented this cycle is the final one of the block.
  assign w_last = r_rd && (r_received == (r_len - CNT_W'(1)));

  assign w_len_clamped = (length > CNT_W'(MAX_BLOCK_SIZE)) ? CNT_W'(MAX_BLOCK_SIZE) : length;
  assign w_issued_next = r_issued + {{(CNT_W-1){1'b0}}, w_rden};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_rate     <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_rd       <= 1'b0;
      r_dout     <= '0;
      r_done0    <= 1'b0;
    end else begin
      r_rd    <= w_rden;
      r_done0 <= 1'b0;
      r_issued <= w_issued_next;
      if (r_rd) begin
        r_dout     <= din;
        r_received <= r_received + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          // r_done0 marks the done cycle of a zero-length block; a start
          // arriving alongside it is dropped.
          if (start && !r_done0) begin
            r_len      <= w_len_clamped;
            r_rate     <= rate;
            r_issued   <= '0;
            r_received <= '0;
            if (w_len_clamped == '0) begin
              r_done0 <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_last) begin
            r_state <= IDLE;
          end else if (w_issued_next == r_len) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The FIFO presents data the cycle after the read, so the word is passed
  // straight through while valid and held afterwards.
  assign rden       = w_rden;
  assign dout       = r_rd ? din : r_dout;
  assign dout_valid = r_rd;
  assign dout_index = r_received;
  assign busy       = (r_state != IDLE);
  assign done       = r_done0 || w_last;

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side counterpart to the team's FIFO writer. It drains a fixed-length block of words from a standard (non-fall-through) FIFO read port at a programmable pseudo-random rate and presents each word with its block index. It sits at the read end of FIFOs under test and in pipelines that need throttled back-pressure on FIFO outputs.

## Interface
- WIDTH, 8: FIFO word width in bits.
- MAX_BLOCK_SIZE, 1024: largest block length accepted. CNT_W = $clog2(MAX_BLOCK_SIZE+1).
- SEED, 16'hACE1: LFSR reset value. Must be nonzero.

- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to read a block; ignored while busy.
- length  in  CNT_W  block length, sampled with start; values above MAX_BLOCK_SIZE are clamped to MAX_BLOCK_SIZE.
- rate  in  9  read probability ×256, sampled with start; 0 = never read, ≥256 = read every eligible cycle.
- rden  out  1  FIFO read enable.
- din  in  WIDTH  FIFO read data, valid the cycle after an accepted read.
- empty  in  1  FIFO empty flag.
- dout  out  WIDTH  captured word.
- dout_valid  out  1  one-cycle strobe: dout/dout_index valid.
- dout_index  out  CNT_W  position of dout within the block, 0-based.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last word of the block has been presented.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on start, load len_q (clamped length), rate_q, clear issued and received counters. length 0 → stay IDLE, pulse done next cycle, busy stays low. Otherwise → RUN.
- RUN: gate = (lfsr[15:8] < rate_q), true when rate_q ≥ 256. rden = gate & !empty & (issued < len_q), combinational on state/registers/empty. Every accepted read increments issued. When issued reaches len_q → DRAIN (or directly IDLE if the final word is captured in the same cycle).
- DRAIN: wait for the outstanding word. When received reaches len_q → IDLE with done pulsed.
- Capture: rden registered into rd_q. When rd_q is set, dout ← din, dout_index ← received, dout_valid = 1, received increments.
- LFSR: 16-bit Galois, taps 0xB400. It advances every cycle in RUN, whether or not a read occurs, and holds in IDLE/DRAIN.
- rden is never asserted when empty = 1. rden is never asserted outside RUN.
- Reset: state IDLE, all counters 0, lfsr = SEED. rden, dout_valid, busy and done are 0, and dout is 0. A reset mid-block abandons the block with no done pulse; any FIFO word already read is lost.

## Timing
- Read latency: rden at cycle N → dout_valid at N+1 with dout = din sampled at the N+1 edge.
- Throughput: one word per cycle when rate ≥ 256 and the FIFO is not empty.
- start at cycle N → busy high at N+1 and first rden no earlier than N+1.
- done coincides with the dout_valid of index len_q−1. It goes high in the same cycle, and busy falls on the following cycle.
- A start that arrives in the same cycle as done is ignored. A new start is honoured from the first IDLE cycle.
- empty rising in the same cycle a read was gated: no read, and issued is unchanged.

## Structure
- Shared package/header fifo_rd_defs: state encoding (IDLE = 0, RUN = 1, DRAIN = 2), LFSR tap constant 16'hB400, and the rate full-scale constant 256.
- One sub-module: lfsr16 (clk, rst, en, seed parameter, q[15:0]). This is reusable by a synthesizable writer.
- Estimated size: ~200 lines.

## Test plan
- FIFO preloaded with 0x00..0x0F, start with length=16 and rate=256 → 16 consecutive rden cycles, dout 0x00..0x0F with dout_index 0..15, done on the 16th dout_valid.
- rate=0, length=4, FIFO non-empty → rden is never asserted for 200 cycles and busy stays high; after reset, busy=0.
- rate=128, length=64, FIFO always non-empty → all 64 words in order. rden duty is between 35% and 65%, and with SEED=16'hACE1 the rden pattern is bit-exact against the golden model.
- FIFO empty for 10 cycles mid-block, then refilled → rden is low while empty=1, the block completes in order, and there is no duplicate or missing index.
- length=0 → done pulses one cycle after start, with no rden and busy never asserted. length=2000 with MAX_BLOCK_SIZE=1024 → exactly 1024 words are read.
- rst asserted asynchronously mid-block at index 5 → all outputs 0 immediately and no done. A following start with length=3 reads 3 fresh words with indices 0..2.
